// File: rtl/load_store_unit.sv
// Load/store unit between a single-request pipeline port and a word-wide, big-endian data memory.
// Sub-word stores are done as read-modify-write; misaligned or illegal requests return an error without touching memory.
module load_store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [1:0]  dm_memwrite,
    output logic [1:0]  dm_memread,
    input  logic [31:0] dm_rdata
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] word_q, word_d;
    logic        misaligned;

    // Byte lane k sits at bits 31-8k (big-endian), i.e. a right shift of 8*(3-k).
    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic sgn, input logic [1:0] k);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(word >> {~k, 3'b000});
        h = k[1] ? word[15:0] : word[31:16];
        case (size)
            2'b00:   return {{24{sgn & b[7]}}, b};
            2'b01:   return {{16{sgn & h[15]}}, h};
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wd,
                                                input logic [1:0] size, input logic [1:0] k);
        logic [31:0] mask;
        case (size)
            2'b00: begin
                mask = 32'h0000_00FF << {~k, 3'b000};
                return (word & ~mask) | (32'(wd[7:0]) << {~k, 3'b000});
            end
            2'b01: begin
                mask = 32'h0000_FFFF << {~k[1], 4'b0000};
                return (word & ~mask) | (32'(wd[15:0]) << {~k[1], 4'b0000});
            end
            default: return wd;
        endcase
    endfunction

    always_comb begin
        misaligned = (req_size == 2'b11)
                   | ((req_size == 2'b01) & req_addr[0])
                   | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            write_q  <= 1'b0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            word_q   <= '0;
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            word_q   <= word_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        size_d   = size_q;
        signed_d = signed_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        word_d   = word_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d  = req_write;
                    size_d   = req_size;
                    signed_d = req_signed;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    err_d    = misaligned;
                    word_d   = '0;
                    if (misaligned)
                        state_d = RESP;
                    else if (req_write && req_size == 2'b10)
                        state_d = WRITE;
                    else
                        state_d = READ;
                end
            end
            READ: begin
                word_d  = dm_rdata;
                state_d = write_q ? WRITE : RESP;
            end
            WRITE:   state_d = RESP;
            default: if (resp_ready) state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready   = (state_q == IDLE);
        resp_valid  = (state_q == RESP);
        resp_error  = (state_q == RESP) && err_q;
        resp_rdata  = '0;
        if (state_q == RESP && !write_q && !err_q)
            resp_rdata = load_extract(word_q, size_q, signed_q, addr_q[1:0]);
        dm_addr     = (state_q == READ || state_q == WRITE) ? {addr_q[31:2], 2'b00} : '0;
        dm_memread  = (state_q == READ) ? 2'b01 : 2'b00;
        // Gated by rst so a reset landing in WRITE cannot commit the store.
        dm_memwrite = (state_q == WRITE && !rst) ? 2'b01 : 2'b00;
        dm_wdata    = (state_q == WRITE) ? store_merge(word_q, wdata_q, size_q, addr_q[1:0]) : '0;
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a 64-word big-endian memory model.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst, req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_error;
    logic [31:0] resp_rdata, dm_addr, dm_wdata, dm_rdata;
    logic [1:0]  dm_memwrite, dm_memread;
    logic        mem_clr;
    logic [31:0] mem [0:63];
    int          dm_act = 0;
    int          checks = 0;
    int          failures = 0;

    load_store_unit dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_error(resp_error),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_memwrite(dm_memwrite),
        .dm_memread(dm_memread), .dm_rdata(dm_rdata)
    );

    always #5 clk = ~clk;

    assign dm_rdata = mem[dm_addr[7:2]];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
        end else if (dm_memwrite == 2'b01) begin
            mem[dm_addr[7:2]] <= dm_wdata;
        end
        if (dm_memwrite != 2'b00 || dm_memread != 2'b00) dm_act <= dm_act + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for exactly one IDLE cycle; returns in cycle t+1.
    task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_clr = 1'b1;
        tick(); tick();
        rst = 1'b0; mem_clr = 1'b0;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_req_ready got=%b exp=1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL rst_resp_valid got=%b exp=0", resp_valid); end
        checks++; if ({dm_memwrite, dm_memread} !== 4'b0) begin failures++; $display("FAIL rst_dm_ctrl got=%b exp=0000", {dm_memwrite, dm_memread}); end
        checks++; if ({dm_addr, dm_wdata, resp_rdata} !== 96'h0 || resp_error !== 1'b0) begin failures++; $display("FAIL rst_outputs got=%h/%h/%h/%b exp=0", dm_addr, dm_wdata, resp_rdata, resp_error); end
    endtask

    task automatic test_word_store();
        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        checks++; if (dm_memwrite !== 2'b01 || dm_memread !== 2'b00) begin failures++; $display("FAIL ws_memwrite got=%b/%b exp=01/00", dm_memwrite, dm_memread); end
        checks++; if (dm_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL ws_wdata got=%h exp=deadbeef", dm_wdata); end
        checks++; if (dm_addr !== 32'h10) begin failures++; $display("FAIL ws_addr got=%h exp=00000010", dm_addr); end
        tick();
        checks++; if (resp_valid !== 1'b1 || resp_error !== 1'b0 || resp_rdata !== 32'h0) begin failures++; $display("FAIL ws_resp got=%b/%b/%h exp=1/0/0", resp_valid, resp_error, resp_rdata); end
        tick();
        checks++; if (req_ready !== 1'b1 || mem[4] !== 32'hDEADBEEF) begin failures++; $display("FAIL ws_done got=%b/%h exp=1/deadbeef", req_ready, mem[4]); end
    endtask

    task automatic test_loads();
        logic [1:0]  sz [7]  = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10};
        logic        sg [7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] ad [7]  = '{32'h11, 32'h12, 32'h10, 32'h13, 32'h13, 32'h10, 32'h10};
        logic [31:0] ex [7]  = '{32'hFFFFFFAD, 32'h0000BEEF, 32'hFFFFDEAD, 32'h000000EF,
                                 32'hFFFFFFEF, 32'h000000DE, 32'hDEADBEEF};
        for (int i = 0; i < 7; i++) begin
            issue(1'b0, sz[i], sg[i], ad[i], 32'h0);
            checks++; if (dm_memread !== 2'b01 || dm_addr !== 32'h10 || resp_valid !== 1'b0) begin failures++; $display("FAIL ld%0d_read got=%b/%h/%b exp=01/00000010/0", i, dm_memread, dm_addr, resp_valid); end
            tick();
            checks++; if (resp_valid !== 1'b1 || resp_error !== 1'b0 || resp_rdata !== ex[i]) begin failures++; $display("FAIL ld%0d_resp got=%b/%b/%h exp=1/0/%h", i, resp_valid, resp_error, resp_rdata, ex[i]); end
            tick();
        end
    endtask

    task automatic test_subword_store();
        issue(1'b1, 2'b00, 1'b0, 32'h13, 32'h12345655);
        checks++; if (dm_memread !== 2'b01 || dm_memwrite !== 2'b00) begin failures++; $display("FAIL bs_read got=%b/%b exp=01/00", dm_memread, dm_memwrite); end
        tick();
        checks++; if (dm_memwrite !== 2'b01 || dm_wdata !== 32'hDEADBE55) begin failures++; $display("FAIL bs_write got=%b/%h exp=01/deadbe55", dm_memwrite, dm_wdata); end
        tick();
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0) begin failures++; $display("FAIL bs_resp got=%b/%h exp=1/0", resp_valid, resp_rdata); end
        tick();
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        tick();
        checks++; if (resp_rdata !== 32'hDEADBE55) begin failures++; $display("FAIL bs_readback got=%h exp=deadbe55", resp_rdata); end
        tick();
        // Halfword then byte into word 0x14 (initially zero).
        issue(1'b1, 2'b01, 1'b0, 32'h16, 32'h9999CAFE);
        tick();
        checks++; if (dm_wdata !== 32'h0000CAFE || dm_addr !== 32'h14) begin failures++; $display("FAIL hs_write got=%h/%h exp=0000cafe/00000014", dm_wdata, dm_addr); end
        tick(); tick();
        issue(1'b1, 2'b00, 1'b0, 32'h14, 32'h00000077);
        tick(); tick(); tick();
        issue(1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
        tick();
        checks++; if (resp_rdata !== 32'h7700CAFE) begin failures++; $display("FAIL hs_readback got=%h exp=7700cafe", resp_rdata); end
        tick();
    endtask

    task automatic test_errors();
        logic        wr [3] = '{1'b0, 1'b0, 1'b1};
        logic [1:0]  sz [3] = '{2'b10, 2'b11, 2'b01};
        logic [31:0] ad [3] = '{32'h12, 32'h10, 32'h11};
        int          act0;
        for (int i = 0; i < 3; i++) begin
            act0 = dm_act;
            issue(wr[i], sz[i], 1'b0, ad[i], 32'hFFFFFFFF);
            checks++; if (resp_valid !== 1'b1 || resp_error !== 1'b1 || resp_rdata !== 32'h0) begin failures++; $display("FAIL err%0d_resp got=%b/%b/%h exp=1/1/0", i, resp_valid, resp_error, resp_rdata); end
            tick();
            checks++; if (dm_act !== act0 || req_ready !== 1'b1) begin failures++; $display("FAIL err%0d_nomem got=%0d/%b exp=%0d/1", i, dm_act, req_ready, act0); end
        end
        checks++; if (mem[4] !== 32'hDEADBE55) begin failures++; $display("FAIL err_mem got=%h exp=deadbe55", mem[4]); end
    endtask

    task automatic test_backpressure();
        resp_ready = 1'b0;
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEADBE55 || req_ready !== 1'b0) begin failures++; $display("FAIL bp_hold%0d got=%b/%h/%b exp=1/deadbe55/0", i, resp_valid, resp_rdata, req_ready); end
            tick();
        end
        // A request offered while the response drains must not be taken.
        resp_ready = 1'b1;
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 32'h14;
        tick();
        req_valid = 1'b0;
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin failures++; $display("FAIL bp_release got=%b/%b exp=1/0", req_ready, resp_valid); end
        tick();
        checks++; if (req_ready !== 1'b1 || dm_memread !== 2'b00) begin failures++; $display("FAIL bp_noaccept got=%b/%b exp=1/00", req_ready, dm_memread); end
    endtask

    task automatic test_reset_abort();
        issue(1'b1, 2'b10, 1'b0, 32'h18, 32'h11223344);
        tick(); tick();
        issue(1'b1, 2'b01, 1'b0, 32'h18, 32'h0000BBBB);
        tick();
        rst = 1'b1;
        #1;
        checks++; if (dm_memwrite !== 2'b00) begin failures++; $display("FAIL ra_memwrite got=%b exp=00", dm_memwrite); end
        tick();
        rst = 1'b0;
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem[6] !== 32'h11223344) begin failures++; $display("FAIL ra_state got=%b/%b/%h exp=1/0/11223344", req_ready, resp_valid, mem[6]); end
        tick();
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL ra_noresp got=%b exp=0", resp_valid); end
        resp_ready = 1'b0;
        issue(1'b0, 2'b10, 1'b0, 32'h18, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; resp_ready = 1'b1;
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_rdata !== 32'h0) begin failures++; $display("FAIL rr_drop got=%b/%b/%h exp=0/1/0", resp_valid, req_ready, resp_rdata); end
    endtask

    initial begin
        rst = 1'b1; mem_clr = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b1;
        test_reset();
        test_word_store();
        test_loads();
        test_subword_store();
        test_errors();
        test_backpressure();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Ports:
- clk  in  1  single rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  access request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_signed  in  1  sign-extend sub-word loads.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  32  load result, 0 for stores.
- resp_error  out  1  misaligned or illegal access.
- dm_addr  out  32  word address to data memory.
- dm_wdata  out  32  word written to data memory.
- dm_memwrite  out  2  01 = write word at next posedge, else 00.
- dm_memread  out  2  01 = read enable, else 00.
- dm_rdata  in  32  combinational read word from memory, big-endian (byte at addr+0 in bits 31:24).

Function
REQ-003 FSM states SHALL be IDLE, READ, WRITE and RESP; req_ready SHALL be 1 only in IDLE.
REQ-004 A request SHALL be accepted on a cycle with IDLE & req_valid; all req_* fields SHALL be registered on acceptance.
REQ-005 Misalignment SHALL be detected in IDLE: halfword with addr[0]=1, word with addr[1:0]!=0, or req_size=11.
REQ-006 On misalignment the block SHALL go IDLE->RESP with resp_error=1 and resp_rdata=0, and SHALL issue no dm_memread or dm_memwrite.
REQ-007 Load transitions SHALL be IDLE->READ->RESP.
REQ-008 Word-store transitions SHALL be IDLE->WRITE->RESP.
REQ-009 Byte- and halfword-store transitions SHALL be IDLE->READ->WRITE->RESP (read-modify-write).
REQ-010 dm_addr SHALL equal {addr[31:2],2'b00} in READ and WRITE states, and 0 otherwise.
REQ-011 In READ, dm_memread SHALL be 01 and dm_rdata SHALL be captured into an internal word register at the clock edge; dm_memread SHALL be 00 in all other states.
REQ-012 In WRITE, dm_memwrite SHALL be 01 and dm_wdata SHALL hold the merged word; dm_memwrite SHALL be 00 in all other states and whenever rst=1.
REQ-013 Byte offset k=addr[1:0]: the load byte SHALL be word[31-8k -: 8]; the load halfword SHALL be word[31:16] for k=0 and word[15:0] for k=2.
REQ-014 Sub-word loads SHALL be zero-extended when req_signed=0 and sign-extended when req_signed=1; word loads SHALL pass unchanged.
REQ-015 Store merge SHALL replace only the addressed lane with req_wdata[7:0] (byte) or req_wdata[15:0] (halfword); all other lanes SHALL come from the captured word.
REQ-016 A word store SHALL write req_wdata unchanged.
REQ-017 Latency from the acceptance cycle t SHALL be: error response at t+1; load or word store at t+2; sub-word store at t+3.
REQ-018 In RESP, resp_valid SHALL be 1, and resp_rdata and resp_error SHALL be held stable until resp_ready=1.
REQ-019 When resp_ready=1 in RESP, the block SHALL return to IDLE next cycle; a new request SHALL not be accepted in the same cycle.
REQ-020 Address bits [31:8] SHALL be passed through unchecked; the memory decodes bits [7:0] only.

Reset
REQ-021 On rst=1 at a clock edge, the state SHALL become IDLE and all outputs SHALL be 0 except req_ready=1, with all internal registers cleared.
REQ-022 Reset during READ or WRITE SHALL abort the access with no memory write and no response; reset in RESP SHALL drop the pending response.

Verification
REQ-023 Word store 0xDEADBEEF at 0x10 -> dm_memwrite=01 at t+1 with dm_wdata=0xDEADBEEF; resp_valid=1 at t+2 with resp_error=0.
REQ-024 After REQ-023: signed byte load at 0x11 -> resp_rdata=0xFFFFFFAD at t+2; unsigned half load at 0x12 -> 0x0000BEEF.
REQ-025 After REQ-023: byte store 0x55 at 0x13 -> READ at t+1, WRITE at t+2 with dm_wdata=0xDEADBE55, resp_valid=1 at t+3; a following word load at 0x10 -> 0xDEADBE55.
REQ-026 Word load at 0x12, or size=11 -> resp_error=1 at t+1; dm_memread and dm_memwrite stay 00 throughout.
REQ-027 Hold resp_ready=0 for 5 cycles after a load response -> resp_valid and resp_rdata stay constant and req_ready stays 0; IDLE is reached the cycle after resp_ready=1.
REQ-028 Assert rst in the WRITE cycle of a halfword store -> dm_memwrite=00 that cycle, memory word unchanged, and req_ready=1 next cycle.
